// File: rtl/cpu_pkg.sv
// Core-wide shared types and default widths for the out-of-order pipeline.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned TAGW_DEFAULT = 5;

  typedef logic [TAGW_DEFAULT-1:0] rob_tag_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } reg_status_t;

endpackage

// File: rtl/tagged_reg_entry.sv
// One architectural register: value plus busy bit and youngest-producer ROB tag.
module tagged_reg_entry
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned TAGW = TAGW_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_commit_we,
  input  logic [XLEN-1:0] i_commit_data,
  input  logic            i_commit_tag_match,
  input  logic            i_alloc_we,
  input  logic [TAGW-1:0] i_alloc_tag,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_value,
  output logic            o_busy,
  output logic [TAGW-1:0] o_tag
);

  logic [XLEN-1:0] r_value;
  logic            r_busy;
  logic [TAGW-1:0] r_tag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_value <= '0;
      r_busy  <= 1'b0;
      r_tag   <= '0;
    end else begin
      if (i_commit_we) r_value <= i_commit_data;
      // Flush kills the dispatching instruction; alloc beats a same-cycle release.
      if (i_flush) begin
        r_busy <= 1'b0;
      end else if (i_alloc_we) begin
        r_busy <= 1'b1;
        r_tag  <= i_alloc_tag;
      end else if (i_commit_we && r_busy && i_commit_tag_match) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_value = r_value;
  assign o_busy  = r_busy;
  assign o_tag   = r_tag;

endmodule

// File: rtl/tagged_regfile.sv
// Register file with per-register busy/tag scoreboard, commit bypass and flush.
module tagged_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned TAGW  = TAGW_DEFAULT,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  output logic [NRD*TAGW-1:0] o_rd_tag,
  input  logic                i_alloc_en,
  input  logic [AW-1:0]       i_alloc_rd,
  input  logic [TAGW-1:0]     i_alloc_tag,
  input  logic                i_commit_en,
  input  logic [AW-1:0]       i_commit_rd,
  input  logic [TAGW-1:0]     i_commit_tag,
  input  logic [XLEN-1:0]     i_commit_data,
  input  logic                i_flush
);

  logic [NREGS-1:0][XLEN-1:0] w_value;
  logic [NREGS-1:0]           w_busy;
  logic [NREGS-1:0][TAGW-1:0] w_tag;

  // Register 0 is hardwired to zero and never busy.
  assign w_value[0] = '0;
  assign w_busy[0]  = 1'b0;
  assign w_tag[0]   = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    logic w_commit_we;
    logic w_alloc_we;

    assign w_commit_we = i_commit_en && (i_commit_rd == AW'(i));
    assign w_alloc_we  = i_alloc_en && (i_alloc_rd == AW'(i));

    tagged_reg_entry #(
      .XLEN(XLEN),
      .TAGW(TAGW)
    ) u_entry (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_commit_we       (w_commit_we),
      .i_commit_data     (i_commit_data),
      .i_commit_tag_match(w_tag[i] == i_commit_tag),
      .i_alloc_we        (w_alloc_we),
      .i_alloc_tag       (i_alloc_tag),
      .i_flush           (i_flush),
      .o_value           (w_value[i]),
      .o_busy            (w_busy[i]),
      .o_tag             (w_tag[i])
    );
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = i_rd_addr[p*AW +: AW];

    always_comb begin
      o_rd_data[p*XLEN +: XLEN] = w_value[w_addr];
      o_rd_busy[p]              = w_busy[w_addr];
      o_rd_tag[p*TAGW +: TAGW]  = w_tag[w_addr];
      // Bypass the committing value; same-cycle allocation stays invisible.
      if (i_commit_en && (i_commit_rd == w_addr) && (w_addr != '0)) begin
        o_rd_data[p*XLEN +: XLEN] = i_commit_data;
        if (w_busy[w_addr] && (w_tag[w_addr] == i_commit_tag)) o_rd_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tagged_regfile.sv
// Directed bench for tagged_regfile with three 64-bit read ports.
module tb_tagged_regfile;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 3;
  localparam int unsigned TAGW  = 5;
  localparam int unsigned AW    = 5;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic [NRD*AW-1:0]   i_rd_addr;
  logic [NRD*XLEN-1:0] o_rd_data;
  logic [NRD-1:0]      o_rd_busy;
  logic [NRD*TAGW-1:0] o_rd_tag;
  logic                i_alloc_en;
  logic [AW-1:0]       i_alloc_rd;
  logic [TAGW-1:0]     i_alloc_tag;
  logic                i_commit_en;
  logic [AW-1:0]       i_commit_rd;
  logic [TAGW-1:0]     i_commit_tag;
  logic [XLEN-1:0]     i_commit_data;
  logic                i_flush;

  int n_checks = 0;
  int n_errors = 0;

  tagged_regfile #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .TAGW (TAGW)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_rd_busy    (o_rd_busy),
    .o_rd_tag     (o_rd_tag),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_rd   (i_alloc_rd),
    .i_alloc_tag  (i_alloc_tag),
    .i_commit_en  (i_commit_en),
    .i_commit_rd  (i_commit_rd),
    .i_commit_tag (i_commit_tag),
    .i_commit_data(i_commit_data),
    .i_flush      (i_flush)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  // Compare one read port; the tag is only meaningful while busy.
  task automatic check_rd(input string name, input int p, input logic [63:0] data,
                          input logic busy, input logic [TAGW-1:0] tag);
    check({name, ".data"}, o_rd_data[p*XLEN +: XLEN], data);
    check({name, ".busy"}, 64'(o_rd_busy[p]), 64'(busy));
    if (busy) check({name, ".tag"}, 64'(o_rd_tag[p*TAGW +: TAGW]), 64'(tag));
  endtask

  task automatic idle();
    i_alloc_en    = 1'b0;
    i_alloc_rd    = '0;
    i_alloc_tag   = '0;
    i_commit_en   = 1'b0;
    i_commit_rd   = '0;
    i_commit_tag  = '0;
    i_commit_data = '0;
    i_flush       = 1'b0;
  endtask

  // Apply the staged inputs on the next rising edge, then return to idle.
  task automatic step();
    @(posedge i_clk);
    #1;
    idle();
  endtask

  task automatic alloc(input logic [AW-1:0] rd, input logic [TAGW-1:0] tag);
    i_alloc_en  = 1'b1;
    i_alloc_rd  = rd;
    i_alloc_tag = tag;
  endtask

  task automatic commit(input logic [AW-1:0] rd, input logic [TAGW-1:0] tag,
                        input logic [XLEN-1:0] data);
    i_commit_en   = 1'b1;
    i_commit_rd   = rd;
    i_commit_tag  = tag;
    i_commit_data = data;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    i_rd_addr = {a2, a1, a0};
    #1;
  endtask

  initial begin
    idle();
    i_rd_addr = '0;
    i_reset   = 1'b1;
    commit(5'd3, 5'd0, 64'hDEAD);
    step();
    i_reset = 1'b0;
    step();

    // Reset overrides a same-cycle commit
    set_rd(5'd3, 5'd3, 5'd0);
    check_rd("reset_r3", 0, 64'h0, 1'b0, 5'd0);
    check_rd("reset_r0", 2, 64'h0, 1'b0, 5'd0);

    // Allocate and release
    alloc(5'd5, 5'd7);
    step();
    set_rd(5'd5, 5'd0, 5'd0);
    check_rd("alloc_r5", 0, 64'h0, 1'b1, 5'd7);
    commit(5'd5, 5'd7, 64'h1234);
    set_rd(5'd5, 5'd0, 5'd0);
    check_rd("bypass_r5", 0, 64'h1234, 1'b0, 5'd0);
    step();
    set_rd(5'd5, 5'd0, 5'd0);
    check_rd("reg_r5", 0, 64'h1234, 1'b0, 5'd0);

    // Younger producer keeps the register busy
    alloc(5'd5, 5'd7);
    step();
    alloc(5'd5, 5'd9);
    step();
    commit(5'd5, 5'd7, 64'h11);
    set_rd(5'd5, 5'd0, 5'd0);
    check_rd("old_commit_bypass", 0, 64'h11, 1'b1, 5'd9);
    step();
    set_rd(5'd5, 5'd0, 5'd0);
    check_rd("old_commit_reg", 0, 64'h11, 1'b1, 5'd9);
    commit(5'd5, 5'd9, 64'h22);
    step();
    set_rd(5'd5, 5'd0, 5'd0);
    check_rd("young_commit", 0, 64'h22, 1'b0, 5'd0);

    // Same-cycle alloc and commit to one register
    alloc(5'd6, 5'd2);
    step();
    commit(5'd6, 5'd2, 64'h55);
    alloc(5'd6, 5'd4);
    set_rd(5'd6, 5'd0, 5'd0);
    check_rd("ac_bypass", 0, 64'h55, 1'b0, 5'd0);
    step();
    set_rd(5'd6, 5'd0, 5'd0);
    check_rd("ac_reg", 0, 64'h55, 1'b1, 5'd4);

    // Flush with a dropped alloc and an architectural commit
    alloc(5'd1, 5'd1);
    step();
    alloc(5'd2, 5'd5);
    step();
    alloc(5'd7, 5'd6);
    step();
    set_rd(5'd1, 5'd2, 5'd7);
    check_rd("pre_flush_r1", 0, 64'h0, 1'b1, 5'd1);
    check_rd("pre_flush_r7", 2, 64'h0, 1'b1, 5'd6);
    i_flush = 1'b1;
    alloc(5'd8, 5'd3);
    commit(5'd2, 5'd5, 64'hAA);
    step();
    set_rd(5'd1, 5'd2, 5'd7);
    check_rd("flush_r1", 0, 64'h0, 1'b0, 5'd0);
    check_rd("flush_r2", 1, 64'hAA, 1'b0, 5'd0);
    check_rd("flush_r7", 2, 64'h0, 1'b0, 5'd0);
    set_rd(5'd8, 5'd6, 5'd5);
    check_rd("flush_r8", 0, 64'h0, 1'b0, 5'd0);
    check_rd("flush_r6", 1, 64'h55, 1'b0, 5'd0);

    // Register 0 ignores alloc and commit
    alloc(5'd0, 5'd1);
    commit(5'd0, 5'd0, 64'hFF);
    set_rd(5'd0, 5'd0, 5'd0);
    for (int p = 0; p < 3; p++) check_rd($sformatf("r0_bypass_p%0d", p), p, 64'h0, 1'b0, 5'd0);
    step();
    set_rd(5'd0, 5'd0, 5'd0);
    for (int p = 0; p < 3; p++) check_rd($sformatf("r0_reg_p%0d", p), p, 64'h0, 1'b0, 5'd0);

    // Multi-port independence with full 64-bit data
    alloc(5'd10, 5'd12);
    step();
    commit(5'd11, 5'd0, 64'hFEDC_BA98_7654_3210);
    step();
    set_rd(5'd5, 5'd10, 5'd11);
    check_rd("mp_r5", 0, 64'h22, 1'b0, 5'd0);
    check_rd("mp_r10", 1, 64'h0, 1'b1, 5'd12);
    check_rd("mp_r11", 2, 64'hFEDC_BA98_7654_3210, 1'b0, 5'd0);
    set_rd(5'd10, 5'd10, 5'd10);
    for (int p = 0; p < 3; p++) check_rd($sformatf("mp_same_p%0d", p), p, 64'h0, 1'b1, 5'd12);
    commit(5'd10, 5'd12, 64'h1_0000_0001);
    set_rd(5'd10, 5'd5, 5'd10);
    check_rd("mp_byp_p0", 0, 64'h1_0000_0001, 1'b0, 5'd0);
    check_rd("mp_byp_p1", 1, 64'h22, 1'b0, 5'd0);
    check_rd("mp_byp_p2", 2, 64'h1_0000_0001, 1'b0, 5'd0);
    step();
    set_rd(5'd10, 5'd11, 5'd6);
    check_rd("mp_after_r10", 0, 64'h1_0000_0001, 1'b0, 5'd0);
    check_rd("mp_after_r11", 1, 64'hFEDC_BA98_7654_3210, 1'b0, 5'd0);
    check_rd("mp_after_r6", 2, 64'h55, 1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
